// File: rtl/score_keeper.sv
// score_keeper
//   Keeps the score for a DDR-style game. Hit and miss judgements come in as levels, and this
//   block edge-detects them into score and combo updates. It also runs the game FSM
//   (idle/play/done). The 9-bit score output feeds the 3-digit seven-segment display decoder.
//
// Build option:
//   SCORE_KEEPER_HIGH_SCORE_EN  when defined, keeps a high score that survives across games
//                               and flags a new record on game end. When undefined,
//                               high_score_o and new_record_o are tied to zero.
//
// Ports:
//   clk_i         system clock
//   reset_ni      synchronous active-low reset
//   start_i       level; rising edge starts a game (from idle or done)
//   hit_i         level; rising edge is one hit
//   miss_i        level; rising edge is one miss (wins over a simultaneous hit)
//   end_game_i    level; rising edge ends the game (wins over hit/miss that cycle)
//   score_o       current score, saturates at MAX_SCORE
//   combo_o       consecutive-hit count, saturates at all-ones
//   playing_o     high while in play
//   done_o        high while in done
//   high_score_o  best finished score since reset
//   new_record_o  high in done when the last game beat the previous high score
module score_keeper #(
  parameter int unsigned MAX_SCORE    = 511,
  parameter int unsigned COMBO_W      = 7,
  parameter int unsigned COMBO_THRESH = 4,
  parameter int unsigned BONUS        = 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               hit_i,
  input  logic               miss_i,
  input  logic               end_game_i,
  output logic [8:0]         score_o,
  output logic [COMBO_W-1:0] combo_o,
  output logic               playing_o,
  output logic               done_o,
  output logic [8:0]         high_score_o,
  output logic               new_record_o
);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  localparam logic [COMBO_W-1:0] ComboMax = '1;
  localparam logic [9:0]         MaxSum   = 10'(MAX_SCORE);
  localparam logic [9:0]         BonusPts = 10'(1 + BONUS);

  state_e state_q, state_d;

  logic start_q, hit_q, miss_q, end_game_q;
  logic start_rise, hit_rise, miss_rise, end_rise;

  logic [8:0]         score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [9:0]         pts, sum;

  assign start_rise = start_i & ~start_q;
  assign hit_rise   = hit_i & ~hit_q;
  assign miss_rise  = miss_i & ~miss_q;
  assign end_rise   = end_game_i & ~end_game_q;

  // A new game may start only from idle or done; a start edge during play is ignored.
  logic new_game;
  assign new_game = start_rise & (state_q != StPlay);

  // Game-ending edge. High-score bookkeeping keys off this signal.
  logic game_over;
  assign game_over = (state_q == StPlay) & end_rise;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_rise) state_d = StPlay;
      StPlay:  if (end_rise)   state_d = StDone;
      StDone:  if (start_rise) state_d = StPlay;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    playing_o = (state_q == StPlay);
    done_o    = (state_q == StDone);
  end

  // Score and combo next state. The bonus is decided from the combo value before this hit
  // is counted. The sum is 10 bits wide so the clamp sees any overflow past 511.
  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    pts     = (32'(combo_q) >= COMBO_THRESH) ? BonusPts : 10'd1;
    sum     = {1'b0, score_q} + pts;
    if (new_game) begin
      score_d = '0;
      combo_d = '0;
    end else if (state_q == StPlay && !end_rise) begin
      if (miss_rise) begin
        combo_d = '0;
      end else if (hit_rise) begin
        score_d = (sum > MaxSum) ? MaxSum[8:0] : sum[8:0];
        if (combo_q != ComboMax) combo_d = combo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      start_q    <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      end_game_q <= 1'b0;
      score_q    <= '0;
      combo_q    <= '0;
    end else begin
      start_q    <= start_i;
      hit_q      <= hit_i;
      miss_q     <= miss_i;
      end_game_q <= end_game_i;
      score_q    <= score_d;
      combo_q    <= combo_d;
    end
  end

  assign score_o = score_q;
  assign combo_o = combo_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [8:0] high_score_q, high_score_d;
  logic       new_record_q, new_record_d;

  always_comb begin
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    if (new_game) begin
      new_record_d = 1'b0;
    end else if (game_over) begin
      if (score_q > high_score_q) begin
        high_score_d = score_q;
        new_record_d = 1'b1;
      end else begin
        new_record_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      high_score_q <= '0;
      new_record_q <= 1'b0;
    end else begin
      high_score_q <= high_score_d;
      new_record_q <= new_record_d;
    end
  end

  assign high_score_o = high_score_q;
  assign new_record_o = new_record_q;
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign high_score_o     = 9'd0;
  assign new_record_o     = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, hit, miss, end_game;
  logic [8:0] score, high_score;
  logic [6:0] combo;
  logic       playing, done, new_record;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .hit_i        (hit),
    .miss_i       (miss),
    .end_game_i   (end_game),
    .score_o      (score),
    .combo_o      (combo),
    .playing_o    (playing),
    .done_o       (done),
    .high_score_o (high_score),
    .new_record_o (new_record)
  );

  // One-cycle pulse on the chosen inputs; returns at the negedge after the update edge.
  task automatic pulse(input logic s, input logic h, input logic m, input logic e);
    @(negedge clk);
    start = s; hit = h; miss = m; end_game = e;
    @(negedge clk);
    start = 0; hit = 0; miss = 0; end_game = 0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) pulse(0, 1, 0, 0);
  endtask

  task automatic test_reset;
    reset_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      hit = ~hit;
    end
    hit = 0;
    @(negedge clk);
    checks++;
    if (score !== 9'd0 || combo !== 7'd0 || playing !== 1'b0 || done !== 1'b0 ||
        high_score !== 9'd0 || new_record !== 1'b0) begin
      failures++;
      $display("FAIL reset: score=%0d combo=%0d playing=%b done=%b hs=%0d nr=%b (want all 0)",
               score, combo, playing, done, high_score, new_record);
    end
    reset_n = 1;
    // Hits in idle do nothing.
    hits(1);
    checks++;
    if (score !== 9'd0 || combo !== 7'd0) begin
      failures++;
      $display("FAIL idle_hit: score=%0d combo=%0d want 0 0", score, combo);
    end
  endtask

  task automatic test_hits;
    int exp_score [5] = '{1, 2, 3, 4, 6};
    pulse(1, 0, 0, 0);
    checks++;
    if (playing !== 1'b1 || done !== 1'b0 || score !== 9'd0) begin
      failures++;
      $display("FAIL start: playing=%b done=%b score=%0d want 1 0 0", playing, done, score);
    end
    for (int i = 0; i < 5; i++) begin
      hits(1);
      checks++;
      if (score !== 9'(exp_score[i]) || combo !== 7'(i + 1)) begin
        failures++;
        $display("FAIL hit%0d: score=%0d combo=%0d want %0d %0d", i, score, combo,
                 exp_score[i], i + 1);
      end
    end
  endtask

  task automatic test_miss;
    pulse(0, 0, 1, 0);
    checks++;
    if (score !== 9'd6 || combo !== 7'd0) begin
      failures++;
      $display("FAIL miss: score=%0d combo=%0d want 6 0", score, combo);
    end
    hits(1);
    checks++;
    if (score !== 9'd7 || combo !== 7'd1) begin
      failures++;
      $display("FAIL hit_after_miss: score=%0d combo=%0d want 7 1", score, combo);
    end
    pulse(0, 1, 1, 0);
    checks++;
    if (score !== 9'd7 || combo !== 7'd0) begin
      failures++;
      $display("FAIL hit_miss_tie: score=%0d combo=%0d want 7 0", score, combo);
    end
  endtask

  task automatic test_end_game;
    int exp_hs;
    int exp_nr;
    pulse(0, 1, 0, 1);
    checks++;
    if (done !== 1'b1 || playing !== 1'b0 || score !== 9'd7 || combo !== 7'd0) begin
      failures++;
      $display("FAIL end_game: done=%b playing=%b score=%0d combo=%0d want 1 0 7 0",
               done, playing, score, combo);
    end
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    exp_hs = 7; exp_nr = 1;
`else
    exp_hs = 0; exp_nr = 0;
`endif
    checks++;
    if (high_score !== 9'(exp_hs) || new_record !== 1'(exp_nr)) begin
      failures++;
      $display("FAIL record1: hs=%0d nr=%b want %0d %0d", high_score, new_record, exp_hs, exp_nr);
    end
    hits(2);
    checks++;
    if (score !== 9'd7 || done !== 1'b1) begin
      failures++;
      $display("FAIL hit_in_done: score=%0d done=%b want 7 1", score, done);
    end
    pulse(1, 0, 0, 0);
    checks++;
    if (playing !== 1'b1 || score !== 9'd0 || combo !== 7'd0 || new_record !== 1'b0) begin
      failures++;
      $display("FAIL restart: playing=%b score=%0d combo=%0d nr=%b want 1 0 0 0",
               playing, score, combo, new_record);
    end
    hits(3);
    pulse(0, 0, 0, 1);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    exp_hs = 7; exp_nr = 0;
`else
    exp_hs = 0; exp_nr = 0;
`endif
    checks++;
    if (score !== 9'd3 || done !== 1'b1 || high_score !== 9'(exp_hs) ||
        new_record !== 1'(exp_nr)) begin
      failures++;
      $display("FAIL record2: score=%0d done=%b hs=%0d nr=%b want 3 1 %0d %0d",
               score, done, high_score, new_record, exp_hs, exp_nr);
    end
  endtask

  task automatic test_held_and_saturate;
    pulse(1, 0, 0, 0);
    @(negedge clk);
    hit = 1;
    repeat (20) @(negedge clk);
    hit = 0;
    checks++;
    if (score !== 9'd1 || combo !== 7'd1) begin
      failures++;
      $display("FAIL held_hit: score=%0d combo=%0d want 1 1", score, combo);
    end
    hits(3);
    hits(253);
    checks++;
    if (score !== 9'd510 || combo !== 7'd127) begin
      failures++;
      $display("FAIL near_max: score=%0d combo=%0d want 510 127", score, combo);
    end
    hits(1);
    checks++;
    if (score !== 9'd511) begin
      failures++;
      $display("FAIL clamp: score=%0d want 511", score);
    end
    hits(2);
    checks++;
    if (score !== 9'd511 || combo !== 7'd127) begin
      failures++;
      $display("FAIL hold_max: score=%0d combo=%0d want 511 127", score, combo);
    end
    pulse(1, 0, 0, 0);
    checks++;
    if (playing !== 1'b1 || score !== 9'd511) begin
      failures++;
      $display("FAIL start_in_play: playing=%b score=%0d want 1 511", playing, score);
    end
  endtask

  task automatic test_reset_midgame;
    int exp_hs;
    pulse(0, 0, 0, 1);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    exp_hs = 511;
`else
    exp_hs = 0;
`endif
    checks++;
    if (high_score !== 9'(exp_hs)) begin
      failures++;
      $display("FAIL record3: hs=%0d want %0d", high_score, exp_hs);
    end
    pulse(1, 0, 0, 0);
    hits(27);
    checks++;
    if (score !== 9'd50 || playing !== 1'b1) begin
      failures++;
      $display("FAIL score50: score=%0d playing=%b want 50 1", score, playing);
    end
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    checks++;
    if (playing !== 1'b0 || done !== 1'b0 || score !== 9'd0 || combo !== 7'd0 ||
        high_score !== 9'd0 || new_record !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: playing=%b done=%b score=%0d combo=%0d hs=%0d nr=%b want all 0",
               playing, done, score, combo, high_score, new_record);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; start = 0; hit = 0; miss = 0; end_game = 0;
    test_reset;
    test_hits;
    test_miss;
    test_end_game;
    test_held_and_saturate;
    test_reset_midgame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
